// File: rtl/reaction_ctrl.sv
// Reaction-timer round controller: ms tick divider, LFSR pre-delay, reaction
// timing with saturation, and high-score tracking for the HEX/LED display path.
module reaction_ctrl #(
  parameter int          TICK_DIV       = 50000,
  parameter int          TIME_W         = 14,
  parameter int          MAX_MS         = 9999,
  parameter int          MIN_DELAY_MS   = 1000,
  parameter int          RANGE_LOG2     = 11,
  parameter int          DLY_W          = 13,
  parameter logic [15:0] LFSR_SEED      = 16'hACE1,
  parameter bit          FALSE_START_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              react,
  input  logic              show_hi,
  input  logic              clear_hi,
  input  logic              buffs_mode,
  output logic [2:0]        state,
  output logic              go_led,
  output logic              ms_tick,
  output logic [TIME_W-1:0] react_time,
  output logic [TIME_W-1:0] hi_score,
  output logic              hi_valid,
  output logic              new_hi,
  output logic              timeout,
  output logic              false_start
);

  typedef enum logic [2:0] {
    HI_SCORE    = 3'd0,
    DELAYING    = 3'd1,
    TIMING      = 3'd2,
    DISPLAYING  = 3'd3,
    GO_BUFFS    = 3'd4,
    FALSE_START = 3'd5
  } state_t;

  localparam int                TCW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TCW-1:0]    TICK_LAST = TCW'(TICK_DIV - 1);
  localparam logic [15:0]       LFSR_MASK = 16'hB400;
  localparam logic [TIME_W-1:0] MAX_T     = TIME_W'(MAX_MS);
  localparam logic [TIME_W-1:0] MAX_M1    = TIME_W'(MAX_MS - 1);
  localparam logic [DLY_W-1:0]  DLY_MIN   = DLY_W'(MIN_DELAY_MS);

  state_t             cur;
  logic [TCW-1:0]     tick_cnt;
  logic [TCW-1:0]     tick_nxt;
  logic [15:0]        lfsr;
  logic [DLY_W-1:0]   dly_cnt;
  logic [DLY_W-1:0]   dly_load;
  logic [TIME_W-1:0]  ms_cnt;
  logic               hi_better;

  assign state = cur;

  always_comb begin
    tick_nxt = (tick_cnt == TICK_LAST) ? '0 : tick_cnt + TCW'(1);
  end

  // ms_tick is registered so it is high exactly while tick_cnt sits at TICK_LAST.
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt <= '0;
      ms_tick  <= 1'b0;
    end else begin
      tick_cnt <= tick_nxt;
      ms_tick  <= (tick_nxt == TICK_LAST);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr <= LFSR_SEED;
    end else if (lfsr[0]) begin
      lfsr <= (lfsr >> 1) ^ LFSR_MASK;
    end else begin
      lfsr <= lfsr >> 1;
    end
  end

  always_comb begin
    dly_load  = DLY_MIN + DLY_W'(lfsr[RANGE_LOG2-1:0]);
    hi_better = !hi_valid || (ms_cnt < hi_score);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur         <= HI_SCORE;
      dly_cnt     <= '0;
      ms_cnt      <= '0;
      react_time  <= '0;
      hi_score    <= MAX_T;
      hi_valid    <= 1'b0;
      new_hi      <= 1'b0;
      timeout     <= 1'b0;
      false_start <= 1'b0;
      go_led      <= 1'b0;
    end else begin
      new_hi <= 1'b0;
      if (buffs_mode) begin
        cur    <= GO_BUFFS;
        go_led <= 1'b0;
      end else begin
        case (cur)
          HI_SCORE, DISPLAYING, FALSE_START: begin
            if (start) begin
              cur         <= DELAYING;
              dly_cnt     <= dly_load;
              timeout     <= 1'b0;
              false_start <= 1'b0;
            end else if (show_hi && cur != HI_SCORE) begin
              cur <= HI_SCORE;
            end
          end
          DELAYING: begin
            if (react && FALSE_START_EN) begin
              cur         <= FALSE_START;
              false_start <= 1'b1;
            end else if (ms_tick) begin
              if (dly_cnt == '0) begin
                cur    <= TIMING;
                ms_cnt <= '0;
                go_led <= 1'b1;
              end else begin
                dly_cnt <= dly_cnt - DLY_W'(1);
              end
            end
          end
          TIMING: begin
            // react samples ms_cnt before any same-cycle increment, so a react
            // on the final tick is recorded as MAX_MS-1 rather than a timeout.
            if (react) begin
              cur        <= DISPLAYING;
              go_led     <= 1'b0;
              react_time <= ms_cnt;
              if (hi_better && !clear_hi) begin
                hi_score <= ms_cnt;
                hi_valid <= 1'b1;
                new_hi   <= 1'b1;
              end
            end else if (ms_tick) begin
              if (ms_cnt >= MAX_M1) begin
                cur        <= DISPLAYING;
                go_led     <= 1'b0;
                ms_cnt     <= MAX_T;
                react_time <= MAX_T;
                timeout    <= 1'b1;
              end else begin
                ms_cnt <= ms_cnt + TIME_W'(1);
              end
            end
          end
          GO_BUFFS: begin
            cur <= HI_SCORE;
          end
          default: begin
            cur    <= HI_SCORE;
            go_led <= 1'b0;
          end
        endcase
        if (clear_hi) begin
          hi_score <= MAX_T;
          hi_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_reaction_ctrl.sv
// Scoreboard bench for reaction_ctrl: stimulus pushes expected state-transition
// records, a monitor pops and compares them whenever the DUT changes state.
module tb_reaction_ctrl;

  localparam int TICK_DIV     = 4;
  localparam int TIME_W       = 14;
  localparam int MAX_MS       = 20;
  localparam int MIN_DELAY_MS = 3;
  localparam int RANGE_LOG2   = 2;
  localparam int DLY_W        = 4;

  typedef struct {
    int st;
    int rt;
    int hs;
    int hv;
    int to;
    int fs;
    int nh;
    int dly;
  } exp_t;

  logic clk = 1'b0;
  logic rst, start, react, show_hi, clear_hi, buffs_mode;
  logic start_b, react_b, tie0;
  logic [2:0]        state, state_b;
  logic              go_led, ms_tick, go_led_b, ms_tick_b;
  logic [TIME_W-1:0] react_time, hi_score, react_time_b, hi_score_b;
  logic              hi_valid, new_hi, timeout, false_start;
  logic              hi_valid_b, new_hi_b, timeout_b, false_start_b;

  exp_t sb_q[$];
  int   check_count = 0;
  int   fail_count  = 0;
  int   cyc;
  int   m_rt, m_hi, m_hv, m_to, m_fs;
  int   exp_dly;
  bit   mon_en = 1'b0;

  reaction_ctrl #(
    .TICK_DIV(TICK_DIV), .TIME_W(TIME_W), .MAX_MS(MAX_MS), .MIN_DELAY_MS(MIN_DELAY_MS),
    .RANGE_LOG2(RANGE_LOG2), .DLY_W(DLY_W), .LFSR_SEED(16'hACE1), .FALSE_START_EN(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .react(react), .show_hi(show_hi),
    .clear_hi(clear_hi), .buffs_mode(buffs_mode), .state(state), .go_led(go_led),
    .ms_tick(ms_tick), .react_time(react_time), .hi_score(hi_score), .hi_valid(hi_valid),
    .new_hi(new_hi), .timeout(timeout), .false_start(false_start)
  );

  // Second instance with false starts disabled.
  reaction_ctrl #(
    .TICK_DIV(TICK_DIV), .TIME_W(TIME_W), .MAX_MS(MAX_MS), .MIN_DELAY_MS(MIN_DELAY_MS),
    .RANGE_LOG2(RANGE_LOG2), .DLY_W(DLY_W), .LFSR_SEED(16'hACE1), .FALSE_START_EN(1'b0)
  ) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .react(react_b), .show_hi(tie0),
    .clear_hi(tie0), .buffs_mode(tie0), .state(state_b), .go_led(go_led_b),
    .ms_tick(ms_tick_b), .react_time(react_time_b), .hi_score(hi_score_b),
    .hi_valid(hi_valid_b), .new_hi(new_hi_b), .timeout(timeout_b),
    .false_start(false_start_b)
  );

  always #5 clk = ~clk;

  // Non-reset clock edges since the last reset; the LFSR has stepped this often.
  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    check_count++;
    if (actual != expected) begin
      fail_count++;
      $display("[TB] FAIL %s: actual=%0d required=%0d", name, actual, expected);
    end
  endtask

  function automatic logic [15:0] lfsr_after(input int n);
    logic [15:0] v;
    v = 16'hACE1;
    for (int i = 0; i < n; i++) v = v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
    return v;
  endfunction

  function automatic exp_t mk(input int st, input int nh, input int dly);
    exp_t e;
    e.st = st; e.rt = m_rt; e.hs = m_hi; e.hv = m_hv;
    e.to = m_to; e.fs = m_fs; e.nh = nh; e.dly = dly;
    return e;
  endfunction

  task automatic model_reset();
    m_rt = 0; m_hi = MAX_MS; m_hv = 0; m_to = 0; m_fs = 0;
  endtask

  // One-cycle pulse on the chosen inputs; called at a negedge, returns at the next.
  task automatic applyStimulus(input bit s, input bit r, input bit sh, input bit cl);
    start = s; react = r; show_hi = sh; clear_hi = cl;
    @(negedge clk);
    start = 1'b0; react = 1'b0; show_hi = 1'b0; clear_hi = 1'b0;
  endtask

  task automatic waitState(input int st, input int budget);
    int n;
    n = 0;
    while (int'(state) != st && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (int'(state) != st) checkOutput("wait_state", int'(state), st);
  endtask

  task automatic startRound(input bit with_show);
    logic [15:0] lf;
    lf = lfsr_after(cyc);
    exp_dly = MIN_DELAY_MS + (int'(lf) % (1 << RANGE_LOG2)) + 1;
    m_to = 0; m_fs = 0;
    sb_q.push_back(mk(1, 0, -1));
    applyStimulus(1'b1, 1'b0, with_show, 1'b0);
    waitState(1, 4);
  endtask

  task automatic enterTiming();
    sb_q.push_back(mk(2, 0, exp_dly));
    waitState(2, 4 * TICK_DIV * 8 + 8);
  endtask

  task automatic reactAfter(input int k, input bit on_tick, input bit with_clear);
    int cnt, guard, nh;
    cnt = 0; guard = 0; nh = 0;
    while (guard < 200) begin
      if (cnt == k && (!on_tick || ms_tick)) begin
        m_rt = k;
        if (with_clear) begin
          m_hi = MAX_MS; m_hv = 0;
        end else if (m_hv == 0 || k < m_hi) begin
          m_hi = k; m_hv = 1; nh = 1;
        end
        sb_q.push_back(mk(3, nh, -1));
        applyStimulus(1'b0, 1'b1, 1'b0, with_clear);
        waitState(3, 2);
        return;
      end
      if (ms_tick) cnt++;
      @(negedge clk);
      guard++;
    end
    checkOutput("react_window", cnt, k);
  endtask

  task automatic timeoutRound();
    m_rt = MAX_MS; m_to = 1;
    sb_q.push_back(mk(3, 0, -1));
    waitState(3, TICK_DIV * MAX_MS + 8);
  endtask

  task automatic falseStartRound();
    @(negedge clk);
    @(negedge clk);
    m_fs = 1;
    sb_q.push_back(mk(5, 0, -1));
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    waitState(5, 2);
  endtask

  task automatic showHi();
    sb_q.push_back(mk(0, 0, -1));
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    waitState(0, 2);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_state"}, int'(state), 0);
    checkOutput({tag, "_hi_score"}, int'(hi_score), MAX_MS);
    checkOutput({tag, "_hi_valid"}, int'(hi_valid), 0);
    checkOutput({tag, "_react_time"}, int'(react_time), 0);
    checkOutput({tag, "_flags"}, int'({go_led, ms_tick, new_hi, timeout, false_start}), 0);
  endtask

  // Monitor: every state change must match the oldest expected record.
  initial begin : monitor
    logic [2:0] prev;
    int dcnt;
    bit nh_next;
    exp_t e;
    prev = 3'd0; dcnt = 0; nh_next = 1'b0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (nh_next) begin
          checkOutput("new_hi_one_cycle", int'(new_hi), 0);
          nh_next = 1'b0;
        end
        if (state != prev) begin
          if (sb_q.size() == 0) begin
            checkOutput("unexpected_transition", int'(state), int'(prev));
          end else begin
            e = sb_q.pop_front();
            checkOutput($sformatf("st%0d_state", e.st), int'(state), e.st);
            checkOutput($sformatf("st%0d_react_time", e.st), int'(react_time), e.rt);
            checkOutput($sformatf("st%0d_hi_score", e.st), int'(hi_score), e.hs);
            checkOutput($sformatf("st%0d_hi_valid", e.st), int'(hi_valid), e.hv);
            checkOutput($sformatf("st%0d_timeout", e.st), int'(timeout), e.to);
            checkOutput($sformatf("st%0d_false_start", e.st), int'(false_start), e.fs);
            checkOutput($sformatf("st%0d_go_led", e.st), int'(go_led), (e.st == 2) ? 1 : 0);
            checkOutput($sformatf("st%0d_new_hi", e.st), int'(new_hi), e.nh);
            if (e.dly >= 0) checkOutput("delay_ticks", dcnt, e.dly);
            nh_next = 1'b1;
          end
          if (state == 3'd1) dcnt = 0;
          prev = state;
        end
        if (state == 3'd1 && ms_tick) dcnt++;
      end else begin
        prev = state;
      end
    end
  end

  initial begin
    int n, p, kind;
    rst = 1'b1; start = 1'b0; react = 1'b0; show_hi = 1'b0; clear_hi = 1'b0;
    buffs_mode = 1'b0; start_b = 1'b0; react_b = 1'b0; tie0 = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checkResetValues("reset");

    n = 0;
    while (!ms_tick && n < 10) begin @(negedge clk); n++; end
    p = 0;
    do begin @(negedge clk); p++; end while (!ms_tick && p < 10);
    checkOutput("tick_period", p, TICK_DIV);

    // False starts disabled: react during the pre-delay is ignored.
    start_b = 1'b1; @(negedge clk); start_b = 1'b0;
    checkOutput("b_delaying", int'(state_b), 1);
    @(negedge clk);
    react_b = 1'b1; @(negedge clk); react_b = 1'b0;
    checkOutput("b_react_ignored", int'(state_b), 1);
    checkOutput("b_false_start", int'(false_start_b), 0);
    n = 0;
    while (int'(state_b) != 2 && n < 60) begin @(negedge clk); n++; end
    checkOutput("b_reaches_timing", int'(state_b), 2);

    @(negedge clk);
    mon_en = 1'b1;
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);

    startRound(1'b0); enterTiming(); reactAfter(7, 1'b0, 1'b0);
    startRound(1'b0); enterTiming();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    reactAfter(9, 1'b0, 1'b0);
    startRound(1'b0); enterTiming(); reactAfter(7, 1'b0, 1'b0);
    startRound(1'b0); enterTiming(); timeoutRound();
    startRound(1'b0); enterTiming(); reactAfter(MAX_MS - 1, 1'b1, 1'b0);
    startRound(1'b0); falseStartRound();
    showHi();
    startRound(1'b0); falseStartRound();
    startRound(1'b1); enterTiming(); reactAfter(2, 1'b1, 1'b0);

    startRound(1'b0); enterTiming();
    repeat (3) @(negedge clk);
    sb_q.push_back(mk(4, 0, -1));
    buffs_mode = 1'b1;
    @(negedge clk);
    waitState(4, 3);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    repeat (8) @(negedge clk);
    sb_q.push_back(mk(0, 0, -1));
    buffs_mode = 1'b0;
    @(negedge clk);
    waitState(0, 3);

    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    m_hi = MAX_MS; m_hv = 0;
    startRound(1'b0); enterTiming(); reactAfter(15, 1'b0, 1'b0);
    startRound(1'b0); enterTiming(); reactAfter(4, 1'b0, 1'b1);

    for (int r = 0; r < 8; r++) begin
      kind = $urandom_range(0, 9);
      startRound(1'b0);
      if (kind == 0) begin
        falseStartRound();
      end else begin
        enterTiming();
        if (kind == 1) timeoutRound();
        else reactAfter($urandom_range(0, MAX_MS - 1), 1'b0, 1'b0);
      end
      if ($urandom_range(0, 2) == 0) showHi();
    end

    startRound(1'b0);
    repeat (2) @(negedge clk);
    model_reset();
    sb_q.push_back(mk(0, 0, -1));
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checkResetValues("midreset");
    startRound(1'b0); enterTiming(); reactAfter(5, 1'b0, 1'b0);

    repeat (5) @(negedge clk);
    checkOutput("scoreboard_drained", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", check_count, fail_count);
    $finish;
  end

endmodule
